field_sampler: RTL

FIELD_SAMPLER -- requirements
Module: field_sampler

---
 rtl/lava_pkg.sv | 27 ++
 rtl/field_sampler_sat_accum.sv | 23 ++
 rtl/field_sampler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lava_pkg.sv
// Shared Q16.15 constants, sampler state encoding and display defaults.
package lava_pkg;

    localparam int          Q_FRAC   = 15;
    localparam logic [31:0] Q_ONE    = 32'h0000_8000;
    localparam logic [31:0] Q_MAX    = 32'h7fff_ffff;

    localparam int          DEF_COLS = 32;
    localparam int          DEF_ROWS = 64;

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT,
        SUM,
        WRITE,
        MOVE
    } sampler_state_t;

    // Unsigned add that clamps at Q_MAX; a is assumed already <= Q_MAX.
    function automatic logic [31:0] q_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, Q_MAX}) ? Q_MAX : s[31:0];
    endfunction

endpackage

// File: rtl/field_sampler_sat_accum.sv
// Combinational N-input saturating unsigned adder for Q16.15 weights.
module sat_accum
    import lava_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0][31:0] in_vals,
    output logic [31:0]        sum
);

    logic [31:0] acc;

    // Saturating each step gives min(total, Q_MAX) since every term is non-negative.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = q_sat_add(acc, in_vals[i]);
        end
    end

    assign sum = acc;

endmodule

// File: rtl/field_sampler.sv
// Scans a COLS x ROWS display, gathers one weight per metaball and writes a lit bit per pixel.
// Optional macro SAMPLER_TIMEOUT_EN adds a WAIT timeout and a sticky err output.
module field_sampler
    import lava_pkg::*;
#(
    parameter int          N_BALLS = 3,
    parameter int          COLS    = DEF_COLS,
    parameter int          ROWS    = DEF_ROWS,
    parameter logic [31:0] THRESH  = Q_ONE,
    parameter int          TIMEOUT = 16,
    localparam int         AW      = $clog2(COLS * ROWS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    output logic                    px_stb,
    output logic [31:0]             p_x,
    output logic [31:0]             p_y,
    input  logic [N_BALLS-1:0]      vld,
    input  logic [N_BALLS-1:0][31:0] out,
    output logic                    fb_we,
    output logic [AW-1:0]           fb_addr,
    output logic                    fb_data,
    output logic                    mov_en,
`ifdef SAMPLER_TIMEOUT_EN
    output logic                    err,
`endif
    output logic                    busy
);

    sampler_state_t            state_reg;
    logic [N_BALLS-1:0]        mask_reg;
    logic [N_BALLS-1:0][31:0]  weight_reg;
    logic [31:0]               sum_reg;
    logic [N_BALLS-1:0][31:0]  gated;
    logic [31:0]               acc_sum;
    logic                      mask_full;

`ifdef SAMPLER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]           wait_cnt_reg;
`endif

    // Contributors that never reported (timeout) contribute zero.
    always_comb begin
        gated = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            gated[i] = mask_reg[i] ? weight_reg[i] : 32'd0;
        end
    end

    sat_accum #(.N(N_BALLS)) u_accum (
        .in_vals (gated),
        .sum     (acc_sum)
    );

    assign mask_full = &(mask_reg | vld);
    assign fb_data   = fb_we & (sum_reg >= THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            p_x        <= '0;
            p_y        <= '0;
            mask_reg   <= '0;
            weight_reg <= '0;
            sum_reg    <= '0;
            px_stb     <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            mov_en     <= 1'b0;
            busy       <= 1'b0;
`ifdef SAMPLER_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err          <= 1'b0;
`endif
        end else begin
            px_stb <= 1'b0;
            fb_we  <= 1'b0;
            mov_en <= 1'b0;

            // First vld per contributor wins; repeats within the pixel are ignored.
            if (state_reg == STROBE || state_reg == WAIT) begin
                mask_reg <= mask_reg | vld;
                for (int i = 0; i < N_BALLS; i++) begin
                    if (vld[i] && !mask_reg[i]) begin
                        weight_reg[i] <= out[i];
                    end
                end
            end

            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        p_x       <= '0;
                        p_y       <= '0;
                        mask_reg  <= '0;
                        busy      <= 1'b1;
                        px_stb    <= 1'b1;
                        state_reg <= STROBE;
`ifdef SAMPLER_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                end
                STROBE: begin
                    state_reg <= WAIT;
`ifdef SAMPLER_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                WAIT: begin
                    if (mask_full) begin
                        state_reg <= SUM;
`ifdef SAMPLER_TIMEOUT_EN
                    end else if (wait_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        state_reg <= SUM;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
                    end
                end
                SUM: begin
                    sum_reg   <= acc_sum;
                    fb_addr   <= AW'(p_y * COLS + p_x);
                    fb_we     <= 1'b1;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    mask_reg <= '0;
                    if (p_x == 32'(COLS - 1)) begin
                        p_x <= '0;
                        if (p_y == 32'(ROWS - 1)) begin
                            mov_en    <= 1'b1;
                            state_reg <= MOVE;
                        end else begin
                            p_y       <= p_y + 32'd1;
                            px_stb    <= 1'b1;
                            state_reg <= STROBE;
                        end
                    end else begin
                        p_x       <= p_x + 32'd1;
                        px_stb    <= 1'b1;
                        state_reg <= STROBE;
                    end
                end
                MOVE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
